cv32e40x_data_obi_interface: RTL and testbench

- Sits directly downstream of the single-word data write buffer; converts its valid/ready transaction stream into OBI data-bus requests.
- Guarantees OBI request stability until grant and limits outstanding transactions to MAX_OUTSTANDING.
- Tracks each granted transaction's direction (write enable) in a tag FIFO and returns responses to the LSU tagged with that direction.

---
 rtl/cv32e40x_data_obi_interface.sv | 149 ++++++++++++++
 tb/tb_cv32e40x_data_obi_interface.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_data_obi_interface.sv
// Purpose : turns the write-buffer valid/ready stream into OBI data requests, tracks outstanding transactions.
// Latency : upstream accept -> OBI request 0 cycles; OBI response -> LSU response 0 cycles.
// Backpress: ready_o drops while a request awaits grant or MAX_OUTSTANDING transactions are in flight.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   valid_i/trans_i   upstream transaction, accepted on valid_i && ready_o
//   ready_o           upstream accept
//   obi_req_o/obi_trans_o/obi_gnt_i    OBI address phase
//   obi_rvalid_i/obi_rdata_i/obi_err_i OBI response phase
//   resp_*_o          in-order response to the LSU, tagged with the transaction direction
//   outstanding_o     granted-but-unresponded transaction count

package cv32e40x_data_obi_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic [5:0]  atop;
        logic        dbg;
    } obi_data_req_t;
endpackage

module cv32e40x_data_obi_interface
    import cv32e40x_data_obi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  obi_data_req_t trans_i,
    output logic          ready_o,
    output logic          obi_req_o,
    output obi_data_req_t obi_trans_o,
    input  logic          obi_gnt_i,
    input  logic          obi_rvalid_i,
    input  logic [31:0]   obi_rdata_i,
    input  logic          obi_err_i,
    output logic          resp_valid_o,
    output logic [31:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic          resp_we_o,
    output logic [2:0]    outstanding_o
);

    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        S_PASS = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e        r_state;
    obi_data_req_t r_hold;
    logic [2:0]    r_outstanding;
    // Tag storage sized for the largest legal depth; only entries 0..MAX_OUTSTANDING-1 are used.
    logic [3:0]    r_tags;
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;

    logic w_cnt_ok;
    logic w_req;
    logic w_push;
    logic w_pop;

    assign w_cnt_ok = (r_outstanding < MAX_CNT);

    // Address phase: pass-through in PASS, replay of the captured request in HOLD.
    // The request is squashed during reset so the bus sees the reset in the same cycle.
    always_comb begin
        ready_o     = 1'b0;
        w_req       = 1'b0;
        obi_trans_o = trans_i;
        if (r_state == S_PASS) begin
            ready_o = w_cnt_ok;
            w_req   = valid_i && w_cnt_ok;
        end else begin
            w_req       = 1'b1;
            obi_trans_o = r_hold;
        end
    end

    assign obi_req_o = w_req && !rst;

    assign w_push = obi_req_o && obi_gnt_i;
    // A response with nothing outstanding is a bus protocol violation; ignore it so the
    // counter cannot underflow and the tag FIFO stays consistent.
    assign w_pop  = obi_rvalid_i && (r_outstanding != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_PASS;
            r_hold        <= '0;
            r_outstanding <= 3'd0;
            r_tags        <= 4'd0;
            r_wptr        <= 2'd0;
            r_rptr        <= 2'd0;
        end else begin
            case (r_state)
                S_PASS: begin
                    if (obi_req_o && !obi_gnt_i) begin
                        r_hold  <= trans_i;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (obi_gnt_i) begin
                        r_state <= S_PASS;
                    end
                end
                default: r_state <= S_PASS;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            // Head is read combinationally from the old contents, so a push and pop on the
            // same slot in one cycle still returns the older tag.
            if (w_push) begin
                r_tags[r_wptr] <= obi_trans_o.we;
                r_wptr         <= (r_wptr == LAST_PTR) ? 2'd0 : r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? 2'd0 : r_rptr + 2'd1;
            end
        end
    end

    assign resp_valid_o  = obi_rvalid_i;
    assign resp_rdata_o  = obi_rdata_i;
    assign resp_err_o    = obi_err_i;
    assign resp_we_o     = obi_rvalid_i && r_tags[r_rptr];
    assign outstanding_o = r_outstanding;

    a_no_spurious_rvalid : assert property (@(posedge clk) disable iff (rst)
        obi_rvalid_i |-> (r_outstanding != 3'd0));

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (obi_req_o && !obi_gnt_i) |=> (rst || (obi_req_o && $stable(obi_trans_o))));

endmodule

// File: tb/tb_cv32e40x_data_obi_interface.sv
module tb_cv32e40x_data_obi_interface;
    import cv32e40x_data_obi_pkg::*;

    logic          clk;
    logic          rst;
    logic          valid_i;
    obi_data_req_t trans_i;
    logic          ready_o;
    logic          obi_req_o;
    obi_data_req_t obi_trans_o;
    logic          obi_gnt_i;
    logic          obi_rvalid_i;
    logic [31:0]   obi_rdata_i;
    logic          obi_err_i;
    logic          resp_valid_o;
    logic [31:0]   resp_rdata_o;
    logic          resp_err_o;
    logic          resp_we_o;
    logic [2:0]    outstanding_o;

    int n_checks;
    int n_errors;

    cv32e40x_data_obi_interface #(.MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .trans_i      (trans_i),
        .ready_o      (ready_o),
        .obi_req_o    (obi_req_o),
        .obi_trans_o  (obi_trans_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .resp_we_o    (resp_we_o),
        .outstanding_o(outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obi_data_req_t make_req(input logic [31:0] addr, input logic we);
        obi_data_req_t t;
        t         = '0;
        t.addr    = addr;
        t.we      = we;
        t.be      = 4'hF;
        t.wdata   = addr ^ 32'hA5A5_0000;
        t.memtype = 2'b01;
        t.prot    = 3'b011;
        t.dbg     = 1'b0;
        return t;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cycle_idle();
        @(negedge clk);
        valid_i      = 1'b0;
        trans_i      = '0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'd0;
        obi_err_i    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle_idle();
        cycle_idle();
        n_checks++;
        if (obi_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b want 0", obi_req_o); end
        n_checks++;
        if (outstanding_o !== 3'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", outstanding_o); end
        n_checks++;
        if (ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_checks++;
        if (resp_valid_o !== 1'b0 || resp_we_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_resp got vld=%b we=%b want 0 0", resp_valid_o, resp_we_o);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle_idle();
    endtask

    task automatic test_immediate_grant();
        @(negedge clk);
        valid_i = 1'b1; trans_i = make_req(32'h0000_1000, 1'b1); obi_gnt_i = 1'b1;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b1 || ready_o !== 1'b1) begin
            n_errors++; $display("FAIL imm_req got req=%b rdy=%b want 1 1", obi_req_o, ready_o);
        end
        n_checks++;
        if (obi_trans_o !== make_req(32'h0000_1000, 1'b1)) begin
            n_errors++; $display("FAIL imm_trans got addr=%h want 00001000", obi_trans_o.addr);
        end
        cycle_idle();
        n_checks++;
        if (outstanding_o !== 3'd1) begin n_errors++; $display("FAIL imm_cnt got %0d want 1", outstanding_o); end
        @(negedge clk);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h1122_3344;
        #1;
        n_checks++;
        if (resp_valid_o !== 1'b1 || resp_we_o !== 1'b1 || resp_rdata_o !== 32'h1122_3344 || resp_err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL imm_resp got vld=%b we=%b rdata=%h err=%b want 1 1 11223344 0",
                     resp_valid_o, resp_we_o, resp_rdata_o, resp_err_o);
        end
        cycle_idle();
        n_checks++;
        if (outstanding_o !== 3'd0) begin n_errors++; $display("FAIL imm_drain got %0d want 0", outstanding_o); end
    endtask

    task automatic test_delayed_grant();
        obi_data_req_t exp_t;
        exp_t = make_req(32'h0000_2004, 1'b0);
        @(negedge clk);
        valid_i = 1'b1; trans_i = exp_t; obi_gnt_i = 1'b0;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b1 || ready_o !== 1'b1 || obi_trans_o !== exp_t) begin
            n_errors++; $display("FAIL dly_accept got req=%b rdy=%b addr=%h want 1 1 00002004",
                                 obi_req_o, ready_o, obi_trans_o.addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i   = (i == 1);
            trans_i   = make_req(32'hFFFF_0000 + 32'(i), 1'b1);
            obi_gnt_i = (i == 2);
            #1;
            n_checks++;
            if (obi_req_o !== 1'b1 || ready_o !== 1'b0 || obi_trans_o !== exp_t) begin
                n_errors++; $display("FAIL dly_hold%0d got req=%b rdy=%b addr=%h want 1 0 00002004",
                                     i, obi_req_o, ready_o, obi_trans_o.addr);
            end
        end
        cycle_idle();
        n_checks++;
        if (obi_req_o !== 1'b0 || ready_o !== 1'b1 || outstanding_o !== 3'd1) begin
            n_errors++; $display("FAIL dly_after got req=%b rdy=%b cnt=%0d want 0 1 1",
                                 obi_req_o, ready_o, outstanding_o);
        end
        @(negedge clk);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if (resp_we_o !== 1'b0 || resp_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL dly_resp got vld=%b we=%b want 1 0", resp_valid_o, resp_we_o);
        end
        cycle_idle();
    endtask

    task automatic test_max_outstanding();
        @(negedge clk);
        valid_i = 1'b1; trans_i = make_req(32'h0000_3000, 1'b1); obi_gnt_i = 1'b1;
        @(negedge clk);
        trans_i = make_req(32'h0000_3004, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            trans_i = make_req(32'h0000_3008, 1'b0);
            #1;
            n_checks++;
            if (outstanding_o !== 3'd2 || ready_o !== 1'b0 || obi_req_o !== 1'b0) begin
                n_errors++; $display("FAIL max_block%0d got cnt=%0d rdy=%b req=%b want 2 0 0",
                                     i, outstanding_o, ready_o, obi_req_o);
            end
        end
        @(negedge clk);
        obi_rvalid_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || obi_req_o !== 1'b0 || resp_we_o !== 1'b1) begin
            n_errors++; $display("FAIL max_rvalid got rdy=%b req=%b we=%b want 0 0 1", ready_o, obi_req_o, resp_we_o);
        end
        @(negedge clk);
        obi_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || obi_req_o !== 1'b1 || outstanding_o !== 3'd1) begin
            n_errors++; $display("FAIL max_release got rdy=%b req=%b cnt=%0d want 1 1 1",
                                 ready_o, obi_req_o, outstanding_o);
        end
        // Drain the second write and then the read issued on release.
        @(negedge clk);
        valid_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1;
        #1;
        n_checks++;
        if (resp_we_o !== 1'b1 || outstanding_o !== 3'd2) begin
            n_errors++; $display("FAIL max_drain0 got we=%b cnt=%0d want 1 2", resp_we_o, outstanding_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (resp_we_o !== 1'b0) begin n_errors++; $display("FAIL max_drain1 got we=%b want 0", resp_we_o); end
        cycle_idle();
        n_checks++;
        if (outstanding_o !== 3'd0) begin n_errors++; $display("FAIL max_empty got %0d want 0", outstanding_o); end
    endtask

    // W,R,W,R with overlapping grant and response; the FIFO pointers start mid-array here.
    task automatic test_back_to_back();
        logic [3:0]  issue_we  = 4'b0101; // bit i = direction of the i-th issued transaction
        logic [5:0]  issue_at  = 6'b011011;
        logic [5:0]  resp_at   = 6'b111100;
        logic [2:0]  exp_cnt [6] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1};
        logic [0:0]  exp_we  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int          n_issued = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            valid_i      = issue_at[c];
            obi_gnt_i    = issue_at[c];
            trans_i      = make_req(32'h0000_5000 + 32'(4 * n_issued), issue_we[n_issued[1:0]]);
            obi_rvalid_i = resp_at[c];
            #1;
            n_checks++;
            if (outstanding_o !== exp_cnt[c]) begin
                n_errors++; $display("FAIL b2b_cnt%0d got %0d want %0d", c, outstanding_o, exp_cnt[c]);
            end
            if (resp_at[c]) begin
                n_checks++;
                if (resp_we_o !== exp_we[c][0]) begin
                    n_errors++; $display("FAIL b2b_we%0d got %b want %b", c, resp_we_o, exp_we[c][0]);
                end
            end
            if (issue_at[c]) n_issued++;
        end
        cycle_idle();
        n_checks++;
        if (outstanding_o !== 3'd0) begin n_errors++; $display("FAIL b2b_empty got %0d want 0", outstanding_o); end
    endtask

    task automatic test_error_read();
        @(negedge clk);
        valid_i = 1'b1; trans_i = make_req(32'h0000_4000, 1'b0); obi_gnt_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b1; obi_err_i = 1'b1; obi_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_rdata_o !== 32'hDEAD_BEEF || resp_we_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_resp got vld=%b err=%b rdata=%h we=%b want 1 1 deadbeef 0",
                     resp_valid_o, resp_err_o, resp_rdata_o, resp_we_o);
        end
        cycle_idle();
        n_checks++;
        if (resp_valid_o !== 1'b0 || resp_we_o !== 1'b0 || outstanding_o !== 3'd0) begin
            n_errors++; $display("FAIL err_idle got vld=%b we=%b cnt=%0d want 0 0 0",
                                 resp_valid_o, resp_we_o, outstanding_o);
        end
    endtask

    task automatic test_reset_in_hold();
        @(negedge clk);
        valid_i = 1'b1; trans_i = make_req(32'h0000_6000, 1'b1); obi_gnt_i = 1'b1;
        @(negedge clk);
        trans_i = make_req(32'h0000_6004, 1'b0); obi_gnt_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b1 || outstanding_o !== 3'd1 || obi_trans_o.addr !== 32'h0000_6004) begin
            n_errors++; $display("FAIL rsth_pre got req=%b cnt=%0d addr=%h want 1 1 00006004",
                                 obi_req_o, outstanding_o, obi_trans_o.addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b0) begin n_errors++; $display("FAIL rsth_during got req=%b want 0", obi_req_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b0 || outstanding_o !== 3'd0 || ready_o !== 1'b1) begin
            n_errors++; $display("FAIL rsth_post got req=%b cnt=%0d rdy=%b want 0 0 1",
                                 obi_req_o, outstanding_o, ready_o);
        end
        // A discarded tag must not leak into the first response after reset.
        @(negedge clk);
        valid_i = 1'b1; trans_i = make_req(32'h0000_7000, 1'b0); obi_gnt_i = 1'b1;
        #1;
        n_checks++;
        if (obi_req_o !== 1'b1 || obi_trans_o.addr !== 32'h0000_7000) begin
            n_errors++; $display("FAIL rsth_new got req=%b addr=%h want 1 00007000", obi_req_o, obi_trans_o.addr);
        end
        @(negedge clk);
        valid_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1;
        #1;
        n_checks++;
        if (resp_we_o !== 1'b0 || outstanding_o !== 3'd1) begin
            n_errors++; $display("FAIL rsth_resp got we=%b cnt=%0d want 0 1", resp_we_o, outstanding_o);
        end
        cycle_idle();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        valid_i      = 1'b0;
        trans_i      = '0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'd0;
        obi_err_i    = 1'b0;
        test_reset();
        test_immediate_grant();
        test_delayed_grant();
        test_max_outstanding();
        test_back_to_back();
        test_error_read();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
